ft600_rx_unpack: RTL

//   Downstream consumer of the ft600_mode245 RX path. Watches the rx_buf_written sequence counter,

---
 rtl/ft600_rx_unpack_if.sv | 11 +
 rtl/ft600_rx_unpack.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ft600_rx_unpack_if.sv
// Word stream from the FT600 RX unpacker to the command/data logic.
// Valid/ready handshake; last marks the final word of a buffer.
interface ft600_rx_unpack_if;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/ft600_rx_unpack.sv
// Snapshots each completed FT600 rx_buf and streams it out as 16-bit words,
// counting buffers lost when the consumer falls behind the FT600.
module ft600_rx_unpack #(
    parameter int RX_BUF_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [(8<<RX_BUF_WIDTH)-1:0]   rx_buf,
    input  logic [3:0]                     rx_buf_written,
    ft600_rx_unpack_if.master              out_if,
    output logic                           busy,
    output logic                           overflow,
    output logic [7:0]                     drop_count,
    input  logic                           clear_overflow
);
    localparam int BUF_BITS = 8 << RX_BUF_WIDTH;
    localparam int NWORDS   = BUF_BITS / 16;
    localparam int IDXW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state_q, state_d;
    logic [3:0]            wr_q;
    logic [3:0]            rd_seq_q, rd_seq_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [BUF_BITS-1:0]   shadow_q, shadow_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [15:0]           data_q, data_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            drop_q, drop_d;
    logic [3:0]            diff;
    logic [7:0]            drop_base;
    logic [8:0]            drop_sum;
    logic                  loss;

    assign diff      = wr_q - rd_seq_q;
    // A loss in the same cycle as a clear restarts the count rather than adding to it.
    assign drop_base = clear_overflow ? 8'd0 : drop_q;
    assign drop_sum  = {1'b0, drop_base} + 9'(diff) - 9'd1;

    always_comb begin
        state_d  = state_q;
        rd_seq_d = rd_seq_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        valid_d  = valid_q;
        last_d   = last_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        loss     = 1'b0;
        case (state_q)
            IDLE: begin
                if (diff != 4'd0) begin
                    shadow_d = rx_buf;
                    rd_seq_d = wr_q;
                    idx_d    = '0;
                    valid_d  = 1'b1;
                    data_d   = rx_buf[15:0];
                    last_d   = (LAST_IDX == '0);
                    state_d  = STREAM;
                    if (diff >= 4'd2) begin
                        loss   = 1'b1;
                        ovf_d  = 1'b1;
                        drop_d = drop_sum[8] ? 8'hff : drop_sum[7:0];
                    end
                end
            end
            STREAM: begin
                if (out_if.out_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_q + IDXW'(1);
                        data_d = shadow_q[{idx_d, 4'b0000} +: 16];
                        last_d = (idx_d == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_overflow && !loss) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_q     <= 4'd0;
            rd_seq_q <= 4'd0;
            idx_q    <= '0;
            shadow_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= 16'd0;
            ovf_q    <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            wr_q     <= rx_buf_written;
            rd_seq_q <= rd_seq_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign busy             = (state_q == STREAM);
    assign overflow         = ovf_q;
    assign drop_count       = drop_q;
endmodule
